// File: rtl/l2_cache_responder_if.sv
// L1-facing request/response channel and main-memory port of the L2 responder.
// slave: seen from the cache; master: seen from the surrounding L1/memory side.
interface l2_cache_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [3:0]            req_be_i;
  logic                  resp_valid_o;
  logic [DATA_WIDTH-1:0] resp_data_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [3:0]            mem_be_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  mem_ack_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_data_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output mem_ack_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_data_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/l2_cache_responder.sv
// Word-granular 2-way set-associative L2, write-through / no write-allocate.
// Index = addr[11:2]; tag = {addr[31:12], addr[1:0]}; 1-bit LRU per set
// holding the way to evict next.
// Optional macro L2_STATS_EN adds saturating hit/miss/write counters.
module l2_cache_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 1024,
  parameter int NUM_WAYS   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  l2_cache_responder_if.slave bus
`ifdef L2_STATS_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         wr_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam logic [DATA_WIDTH-1:0] NO_DATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;

  logic [NUM_SETS-1:0]   valid0, valid1, lru;
  logic [TAG_W-1:0]      tag0_mem  [NUM_SETS];
  logic [TAG_W-1:0]      tag1_mem  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data0_mem [NUM_SETS];
  logic [DATA_WIDTH-1:0] data1_mem [NUM_SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit0, hit1, hit;
  logic [WAY_W-1:0]      hit_way, victim_way;
  logic [DATA_WIDTH-1:0] hit_data, merged;
  logic                  fill_en, merge_en, arr_we0, arr_we1;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  accept;

  assign idx    = addr_q[IDX_W+1:2];
  assign tag    = {addr_q[ADDR_WIDTH-1:IDX_W+2], addr_q[1:0]};
  assign accept = bus.req_valid_i && bus.req_ready_o;

  // Tag compare, victim selection and array write strobes for the latched request
  always_comb begin
    hit0       = valid0[idx] && (tag0_mem[idx] == tag);
    hit1       = valid1[idx] && (tag1_mem[idx] == tag);
    hit        = hit0 || hit1;
    hit_way    = hit0 ? 1'b0 : 1'b1;
    hit_data   = hit0 ? data0_mem[idx] : data1_mem[idx];
    victim_way = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);
    merged     = hit_data;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
    // rst_n gating: a reset landing on an ack cycle must not fill
    fill_en   = rst_n && (state == MEM_RD) && bus.mem_ack_i;
    merge_en  = rst_n && (state == LOOKUP) && we_q && hit && (be_q != '0);
    arr_we0   = (fill_en && victim_way == 1'b0) || (merge_en && hit_way == 1'b0);
    arr_we1   = (fill_en && victim_way == 1'b1) || (merge_en && hit_way == 1'b1);
    arr_wdata = fill_en ? bus.mem_rdata_i : merged;
  end

  // Tag/data array write port (contents need no reset; valid bits qualify them)
  always_ff @(posedge clk) begin
    if (arr_we0) begin
      tag0_mem[idx]  <= tag;
      data0_mem[idx] <= arr_wdata;
    end
    if (arr_we1) begin
      tag1_mem[idx]  <= tag;
      data1_mem[idx] <= arr_wdata;
    end
  end

  // Control FSM with registered handshake, response and memory-port outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      valid0           <= '0;
      valid1           <= '0;
      lru              <= '0;
      addr_q           <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      be_q             <= '0;
      bus.req_ready_o  <= 1'b1;
      bus.resp_valid_o <= 1'b0;
      bus.resp_data_o  <= NO_DATA;
      bus.mem_req_o    <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_wdata_o  <= '0;
      bus.mem_be_o     <= '0;
    end else begin
      bus.resp_valid_o <= 1'b0;
      bus.resp_data_o  <= NO_DATA;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q          <= bus.req_addr_i;
            we_q            <= bus.req_we_i;
            wdata_q         <= bus.req_wdata_i;
            be_q            <= bus.req_be_i;
            bus.req_ready_o <= 1'b0;
            state           <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!we_q) begin
            if (hit) begin
              lru[idx]         <= ~hit_way;
              bus.resp_valid_o <= 1'b1;
              bus.resp_data_o  <= hit_data;
              state            <= RESP;
            end else begin
              bus.mem_req_o  <= 1'b1;
              bus.mem_we_o   <= 1'b0;
              bus.mem_addr_o <= addr_q;
              bus.mem_be_o   <= '1;
              state          <= MEM_RD;
            end
          end else if (be_q == '0) begin
            bus.resp_valid_o <= 1'b1;
            state            <= RESP;
          end else begin
            if (hit) lru[idx] <= ~hit_way;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= 1'b1;
            bus.mem_addr_o  <= addr_q;
            bus.mem_wdata_o <= wdata_q;
            bus.mem_be_o    <= be_q;
            state           <= MEM_WR;
          end
        end
        MEM_RD: begin
          if (bus.mem_ack_i) begin
            if (victim_way == 1'b0) valid0[idx] <= 1'b1;
            else                    valid1[idx] <= 1'b1;
            lru[idx]         <= ~victim_way;
            bus.mem_req_o    <= 1'b0;
            bus.resp_valid_o <= 1'b1;
            bus.resp_data_o  <= bus.mem_rdata_i;
            state            <= RESP;
          end
        end
        MEM_WR: begin
          if (bus.mem_ack_i) begin
            bus.mem_req_o    <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.resp_valid_o <= 1'b1;
            state            <= RESP;
          end
        end
        RESP: begin
          bus.req_ready_o <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L2_STATS_EN
  // Saturating event counters: read hits/misses at lookup, writes at accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wr_cnt_o   <= '0;
    end else begin
      if (state == LOOKUP && !we_q && hit && hit_cnt_o != '1)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (state == LOOKUP && !we_q && !hit && miss_cnt_o != '1)
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if (accept && bus.req_we_i && wr_cnt_o != '1)
        wr_cnt_o <= wr_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_responder.sv
// Scoreboard bench for l2_cache_responder: a driver predicts each response
// from a golden memory plus a recency-list cache model, a monitor pops and
// compares on resp_valid_o, and a memory responder serves the mem port.
module tb_l2_cache_responder;
  localparam logic [31:0] IDLE_WORD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l2_cache_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef L2_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o, wr_cnt_o;
  int unsigned exp_hit = 0, exp_miss = 0, exp_wr = 0;
`endif

  l2_cache_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(1024), .NUM_WAYS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef L2_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wr_cnt_o(wr_cnt_o)
`endif
  );

  int unsigned n_cmp = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- golden memory and physical memory ----------------
  logic [31:0] gold [int unsigned];
  logic [31:0] phys [int unsigned];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction

  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    gold[a] = v;
    phys[a] = v;
  endtask

  // ---------------- cache model: two most recent lines per set ----------------
  int unsigned m_cnt [1024];
  logic [31:0] m_mru [1024];
  logic [31:0] m_lru [1024];

  function automatic int unsigned set_of(input logic [31:0] a);
    return {22'd0, a[11:2]};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned s;
    s = set_of(a);
    return (m_cnt[s] >= 1 && m_mru[s] == a) || (m_cnt[s] == 2 && m_lru[s] == a);
  endfunction

  task automatic model_touch(input logic [31:0] a);
    int unsigned s;
    s = set_of(a);
    if (m_cnt[s] == 2 && m_lru[s] == a) begin
      m_lru[s] = m_mru[s];
      m_mru[s] = a;
    end
  endtask

  task automatic model_fill(input logic [31:0] a);
    int unsigned s;
    s = set_of(a);
    if (m_cnt[s] != 0) m_lru[s] = m_mru[s];
    m_mru[s] = a;
    if (m_cnt[s] < 2) m_cnt[s]++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) m_cnt[i] = 0;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    int unsigned lat;
    int unsigned mrd;
    int unsigned mwr;
    int unsigned t_acc;
    int unsigned rd_base;
    int unsigned wr_base;
  } exp_t;
  exp_t sbq[$];

  int unsigned mem_rd_cnt = 0, mem_wr_cnt = 0, mem_wait = 0;
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_we;
  logic [3:0]  cur_be;

  // monitor: compares every presented response against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.resp_valid_o) begin
          if (sbq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
          else begin
            e = sbq.pop_front();
            chk("resp_data", bus.resp_data_o, e.data);
            chk("resp_latency", cyc - e.t_acc, e.lat);
            chk("mem_rd_count", mem_rd_cnt - e.rd_base, e.mrd);
            chk("mem_wr_count", mem_wr_cnt - e.wr_base, e.mwr);
          end
        end else begin
          chk("idle_resp_data", bus.resp_data_o, IDLE_WORD);
        end
      end
    end
  end

  // memory responder: acks after mem_wait extra cycles, checks request fields
  initial begin
    bit busy;
    int unsigned left;
    busy = 0;
    left = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = $urandom();
      if (!rst_n || !bus.mem_req_o) busy = 0;
      else begin
        if (!busy) begin
          busy = 1;
          left = mem_wait;
        end
        if (left == 0) begin
          busy = 0;
          bus.mem_ack_i = 1'b1;
          chk("mem_addr", bus.mem_addr_o, cur_addr);
          chk("mem_we", {31'd0, bus.mem_we_o}, {31'd0, cur_we});
          chk("mem_be", {28'd0, bus.mem_be_o}, {28'd0, cur_we ? cur_be : 4'hF});
          if (!bus.mem_we_o) begin
            bus.mem_rdata_i = phys_rd(bus.mem_addr_o);
            mem_rd_cnt++;
          end else begin
            chk("mem_wdata", bus.mem_wdata_o, cur_wdata);
            phys[bus.mem_addr_o] = merge_be(phys_rd(bus.mem_addr_o), bus.mem_wdata_o, bus.mem_be_o);
            mem_wr_cnt++;
          end
        end else left--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int unsigned guard;
    guard = 0;
    while (!bus.req_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready_o) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int unsigned w);
    exp_t e;
    bit hit;
    int unsigned guard;
    wait_ready();
    mem_wait  = w;
    cur_addr  = a;
    cur_we    = we;
    cur_wdata = wd;
    cur_be    = be;
    hit       = model_hit(a);
    e.rd_base = mem_rd_cnt;
    e.wr_base = mem_wr_cnt;
    e.t_acc   = cyc;
    if (!we) begin
      e.data = gold_rd(a);
      e.mrd  = hit ? 0 : 1;
      e.mwr  = 0;
      e.lat  = hit ? 2 : 3 + w;
      if (hit) model_touch(a);
      else     model_fill(a);
`ifdef L2_STATS_EN
      if (hit) exp_hit++;
      else     exp_miss++;
`endif
    end else begin
      e.data = IDLE_WORD;
      e.mrd  = 0;
`ifdef L2_STATS_EN
      exp_wr++;
`endif
      if (be != 4'h0) begin
        e.mwr   = 1;
        e.lat   = 3 + w;
        gold[a] = merge_be(gold_rd(a), wd, be);
        if (hit) model_touch(a);
      end else begin
        e.mwr = 0;
        e.lat = 2;
      end
    end
    sbq.push_back(e);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = a;
    bus.req_wdata_i = wd;
    bus.req_be_i    = be;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    guard = 0;
    while (sbq.size() != 0 && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    chk("rst_resp_data", bus.resp_data_o, IDLE_WORD);
    chk("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be_o}, 32'd0);
    rst_n = 1'b1;
    model_clear();
    sbq.delete();
`ifdef L2_STATS_EN
    exp_hit = 0;
    exp_miss = 0;
    exp_wr = 0;
`endif
  endtask

  task automatic reset_in_mem_rd();
    int unsigned guard, rd0;
    bit saw;
    issue(1'b0, 32'h0000_0100, 32'd0, 4'h0, 0);
    issue(1'b0, 32'h0000_0100, 32'd0, 4'h0, 0);
    wait_ready();
    cur_addr = 32'h0000_5100;
    cur_we   = 1'b0;
    cur_be   = 4'hF;
    mem_wait = 40;
    rd0      = mem_rd_cnt;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'h0000_5100;
    bus.req_be_i    = 4'h0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    guard = 0;
    while (!bus.mem_req_o && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_mem_rd_started", {31'd0, bus.mem_req_o}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("abort_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("abort_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    rst_n = 1'b1;
    model_clear();
`ifdef L2_STATS_EN
    exp_hit = 0;
    exp_miss = 0;
    exp_wr = 0;
`endif
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid_o) saw = 1;
    end
    chk("abort_no_resp", {31'd0, saw}, 32'd0);
    chk("abort_no_mem_rd", mem_rd_cnt - rd0, 32'd0);
    issue(1'b0, 32'h0000_0100, 32'd0, 4'h0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_be_i    = '0;
    cur_addr = '0; cur_wdata = '0; cur_we = 1'b0; cur_be = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    preset(32'h0000_0100, 32'h1234_5678);
    issue(1'b0, 32'h0000_0100, 32'd0, 4'h0, 2);
    issue(1'b0, 32'h0000_0100, 32'd0, 4'h0, 2);
    issue(1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'b0001, 1);
    issue(1'b0, 32'h0000_0100, 32'd0, 4'h0, 1);
    issue(1'b0, 32'h0000_1100, 32'd0, 4'h0, 0);
    issue(1'b0, 32'h0000_2100, 32'd0, 4'h0, 3);
    issue(1'b0, 32'h0000_0100, 32'd0, 4'h0, 0);
    issue(1'b1, 32'h0000_0400, 32'h1122_3344, 4'hF, 0);
    issue(1'b0, 32'h0000_0400, 32'd0, 4'h0, 1);
    issue(1'b1, 32'h0000_2100, 32'h5566_7788, 4'h0, 0);
    issue(1'b0, 32'h0000_2100, 32'd0, 4'h0, 0);

    reset_in_mem_rd();

    preset(32'h0000_8000, IDLE_WORD);
    issue(1'b0, 32'h0000_8000, 32'd0, 4'h0, 0);
    issue(1'b0, 32'h0000_8000, 32'd0, 4'h0, 0);

    do_reset();
    issue(1'b0, 32'h0000_3000, 32'd0, 4'h0, 1);
    issue(1'b0, 32'h0000_3000, 32'd0, 4'h0, 0);
    issue(1'b0, 32'h0000_4000, 32'd0, 4'h0, 0);
    issue(1'b0, 32'h0000_4000, 32'd0, 4'h0, 0);
    issue(1'b0, 32'h0000_3000, 32'd0, 4'h0, 0);
    issue(1'b1, 32'h0000_3000, 32'hCAFE_0001, 4'hF, 0);
`ifdef L2_STATS_EN
    chk("stats_hit", hit_cnt_o, 32'd3);
    chk("stats_miss", miss_cnt_o, 32'd2);
    chk("stats_wr", wr_cnt_o, 32'd1);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [9:0]  ridx;
      logic [19:0] rtag;
      logic [31:0] ra;
      logic [3:0]  rbe;
      bit          rwe;
      case ($urandom_range(0, 3))
        0:       ridx = 10'h040;
        1:       ridx = 10'h041;
        2:       ridx = 10'h000;
        default: ridx = 10'h3FF;
      endcase
      case ($urandom_range(0, 2))
        0:       rtag = 20'h00000;
        1:       rtag = 20'h00001;
        default: rtag = 20'hFFFFF;
      endcase
      ra  = {rtag, ridx, 2'b00};
      rwe = ($urandom_range(0, 2) == 0);
      rbe = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      issue(rwe, ra, $urandom(), rbe, $urandom_range(0, 3));
    end

`ifdef L2_STATS_EN
    chk("stats_hit_final", hit_cnt_o, exp_hit);
    chk("stats_miss_final", miss_cnt_o, exp_miss);
    chk("stats_wr_final", wr_cnt_o, exp_wr);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running expected finished by time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/l2_cache_responder.md
Name: l2_cache_responder

Overview:
- Word-granular 2-way set-associative L2 that serves L1 miss and write traffic through a valid/ready request channel and a one-cycle response pulse.
- Write-through with no write-allocate, toward a main-memory port with req/ack handshake.
- Sits between l1 data cache and data memory.
- Drives 32'hDEADBEEF on resp_data_o whenever no response is valid, so the L1 fill-qualifier sentinel stays meaningful.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32.
- NUM_SETS, 1024, sets; index = addr[11:2], tag = {addr[31:12], addr[1:0]}, i.e. 22 bits.
- NUM_WAYS, 2, ways per set; only 2 is supported (1-bit LRU per set).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid_i  in  1  L1 request valid
- req_ready_o  out  1  responder can accept a request
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  write data
- req_be_i  in  4  per-byte write enable (bit n -> byte n)
- resp_valid_o  out  1  one-cycle response strobe
- resp_data_o  out  DATA_WIDTH  read data; 32'hDEADBEEF when resp_valid_o = 0 or on write response
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_be_o  out  4  memory byte enables
- mem_ack_i  in  1  memory completes the request this cycle
- mem_rdata_i  in  DATA_WIDTH  read data, valid with mem_ack_i

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE; all valid and LRU bits clear.
  - Next cycle: req_ready_o = 1, resp_valid_o = 0, resp_data_o = 32'hDEADBEEF, mem_req_o = 0, mem_we_o = 0, mem_addr_o/mem_wdata_o = 0, mem_be_o = 0.
  - Reset mid-operation abandons the transaction: no fill, no response, mem_req_o drops the next cycle.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP. req_ready_o = 1 only in IDLE.
- IDLE:
  - req_valid_i & req_ready_o latches addr, we, wdata, be; go to LOOKUP.
- LOOKUP (1 cycle): tag compare on the latched index.
  - Read hit: capture way data, set LRU to point at the other way, go to RESP.
  - Read miss: go to MEM_RD.
  - Write hit: byte-merge req_wdata into the hit way per be bit, set LRU to point at the other way.
  - Write hit or miss with be != 0: go to MEM_WR.
  - Write with be = 0: no array change, no memory access, go to RESP.
  - If both ways hit (illegal), way 0 wins.
- MEM_RD:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = latched addr, mem_be_o = 4'b1111.
  - On mem_ack_i: fill the victim way (way 0 if invalid, else way 1 if invalid, else the LRU way) with tag, valid = 1, data = mem_rdata_i; LRU points at the other way; capture data for response; go to RESP.
  - mem_ack_i is legal in the first MEM_RD cycle.
- MEM_WR:
  - mem_req_o = 1, mem_we_o = 1, mem_wdata_o = latched wdata, mem_be_o = latched be.
  - On mem_ack_i go to RESP. Write miss does not allocate.
- RESP:
  - resp_valid_o = 1 for exactly one cycle; resp_data_o = read word (full 32 bits; L1 masks) or 32'hDEADBEEF for writes; go to IDLE.
  - No backpressure on the response.
- Latency, counted from the accept edge:
  - read hit: resp_valid_o at cycle +2.
  - read miss: +2 + memory wait cycles (minimum +3).
  - write: +3 minimum.
- mem_* outputs are registered and stable while mem_req_o = 1; mem_req_o deasserts the cycle after ack.
- A read returning mem_rdata_i = 32'hDEADBEEF is filled and returned unmodified (documented L1 limitation).

Optional Feature:
- Macro L2_STATS_EN. When defined, adds outputs hit_cnt_o, miss_cnt_o, wr_cnt_o (32 bits each).
  - hit_cnt_o increments on a read hit in LOOKUP; miss_cnt_o on a read miss in LOOKUP; wr_cnt_o on each write accepted.
  - Counters clear on reset and saturate at 32'hFFFF_FFFF.
- When not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, read 0x0000_0100 with memory returning 0x1234_5678 after 2 wait cycles -> one mem read at 0x100, resp_valid_o at cycle +5 with 0x1234_5678; repeat read -> no mem_req_o, response at +2 with 0x1234_5678.
- Write 0x0000_0100 data 0xAABB_CCDD be 4'b0001 after that fill -> mem write with be 0001; subsequent read returns 0x1234_56DD from the array with no mem_req_o.
- Reads of 0x0000_1100, 0x0000_2100, then 0x0000_0100 (same set, set 0x040, after the first test's fill) -> miss on 0x1100 fills way 1; miss on 0x2100 evicts the LRU way (0x0100's way); re-read of 0x0100 misses and issues a mem read.
- Write miss to 0x0000_0400 with be 1111 -> one mem write, no allocate; read 0x0000_0400 -> misses and issues a mem read.
- Deassert rst_n while in MEM_RD -> next cycle mem_req_o = 0, resp_valid_o never asserted, req_ready_o = 1, prior hit address now misses.
- With L2_STATS_EN: 3 read hits, 2 read misses, 1 write -> hit_cnt_o = 3, miss_cnt_o = 2, wr_cnt_o = 1.
